// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared state encoding, default widths and the init
// counter width helper for the memory responder and its storage array.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ACK    = 2'd3
  } state_e;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_ADDR_WIDTH  = 8;
  localparam int DEF_INIT_CYCLES = 48;

  // Width able to hold 0..n; never narrower than one bit so n=0 still builds.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_array_sp.sv
// mem_array_sp: single-port synchronous word array with registered read.
// No reset on the storage or the read register, so it maps onto block RAM.
//   clk_i  - clock
//   we     - write enable (active high), writes wdata to addr on the edge
//   addr   - word address for both read and write
//   wdata  - write data
//   rdata  - registered read data, valid the cycle after addr is presented
module mem_array_sp #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (we) mem_q[addr] <= wdata;
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: responder end of the req/ready/ack memory interface.
// Holds off all requests for INIT_CYCLES clocks after reset, then serves one
// read or write every three clocks (IDLE -> ACCESS -> ACK).
//   clk_i        - clock
//   reset_ni     - asynchronous active-low reset
//   req_i        - request strobe, sampled while ready_o=1
//   write_en_ni  - 0 = write, 1 = read, sampled with req_i
//   address_i    - word address, sampled with req_i
//   data_i       - write data, sampled with req_i
//   ready_o      - request can be accepted on this edge
//   ack_o        - one-cycle completion pulse
//   data_o       - read data, holds the last completed read
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int INIT_CYCLES = DEF_INIT_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  req_i,
  input  logic                  write_en_ni,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  ack_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam int CW = cnt_width(INIT_CYCLES);
  // With INIT_CYCLES=0 the terminal value is 0, which the counter already
  // holds after reset, so INIT is left on the first edge without a special case.
  localparam logic [CW-1:0] CNT_LAST = CW'((INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_n_q, we_n_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ram_we;

  // The array is addressed from the latched request only, so inputs may move
  // freely once the request is taken. Its read register captures on the
  // ACCESS edge and is therefore valid throughout ACK.
  assign ram_we = (state_q == ST_ACCESS) && !we_n_q;

  mem_array_sp #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk_i(clk_i),
    .we   (ram_we),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_n_d  = we_n_q;
    dout_d  = dout_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (req_i) begin
          addr_d  = address_i;
          wdata_d = data_i;
          we_n_d  = write_en_ni;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: state_d = ST_ACK;
      ST_ACK: begin
        // Keep the read result so data_o holds it after ACK.
        if (we_n_q) dout_d = rdata;
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_n_q  <= 1'b1;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_n_q  <= we_n_d;
      dout_q  <= dout_d;
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign ack_o   = (state_q == ST_ACK);
  // During a read ACK the fresh array output is shown directly; otherwise the
  // held copy, which reset clears so data_o reads 0 immediately.
  assign data_o  = (state_q == ST_ACK && we_n_q) ? rdata : dout_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder. A driver
// issues requests; a negedge monitor predicts ready/ack/data from a plain
// word-array model and a timing rule (accept -> ack two edges later).
module tb_mem_responder;

  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int INIT = 48;

  typedef struct {
    logic          we_n;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            ack_k;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req = 1'b0;
  logic          we_n = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din = '0;
  logic          ready, ack;
  logic [DW-1:0] dout;

  mem_responder #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .INIT_CYCLES(INIT)
  ) dut (
    .clk_i      (clk),
    .reset_ni   (reset_n),
    .req_i      (req),
    .write_en_ni(we_n),
    .address_i  (addr),
    .data_i     (din),
    .ready_o    (ready),
    .ack_o      (ack),
    .data_o     (dout)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  int            k = 0;          // rising edges since reset release
  int            acc_k = -100;   // edge index of the last accepted request
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] last_rd = '0;
  txn_t          q[$];
  txn_t          t;
  logic          exp_rdy, exp_ack;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!reset_n) k <= 0;
    else k <= k + 1;
  end

  // Monitor/scoreboard: ready after the hold-off and two edges after each
  // acceptance; ack on the second edge after acceptance; writes commit and
  // reads return model contents at ack; data_o otherwise holds the last read.
  always @(negedge clk) begin
    if (!reset_n) begin
      q.delete();
      last_rd = '0;
      acc_k   = -100;
    end else begin
      exp_rdy = (k >= INIT) && (k >= acc_k + 2);
      chk("ready_o", {31'd0, ready}, {31'd0, exp_rdy});
      exp_ack = (q.size() > 0) && (q[0].ack_k == k);
      chk("ack_o", {31'd0, ack}, {31'd0, exp_ack});
      if (exp_ack) begin
        t = q.pop_front();
        if (!t.we_n) mem[t.a] = t.d;
        else last_rd = mem[t.a];
      end else if (q.size() > 0 && k > q[0].ack_k) begin
        void'(q.pop_front());
      end
      chk("data_o", {16'd0, dout}, {16'd0, last_rd});
      if (exp_rdy && req) begin
        q.push_back('{we_n, addr, din, k + 2});
        acc_k = k + 1;
      end
    end
  end

  task automatic junk();
    we_n = 1'($urandom);
    addr = AW'($urandom);
    din  = DW'($urandom);
  endtask

  // Present a request, wait for acceptance, scramble the inputs through
  // ACCESS, and return during ACK so the next request can be set up.
  task automatic issue(input logic wn, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit hold);
    bit got = 1'b0;
    we_n = wn; addr = a; din = d; req = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (ready) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: ready_o stayed 0, required 1 for addr %h", a);
      req = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req = hold;
    junk();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    // Request held from reset: must not be taken before the hold-off ends.
    we_n = 1'b0; addr = 8'h01; din = 16'h0055; req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_ack", {31'd0, ack}, 32'd0);
    chk("reset_data", {16'd0, dout}, 32'd0);
    reset_n = 1'b1;
    issue(1'b0, 8'h01, 16'h0055, 1'b0);
    issue(1'b1, 8'h01, 16'h0000, 1'b0);
    idle(5);

    // Boundary addresses.
    issue(1'b0, 8'hFF, 16'hA5A5, 1'b0);
    issue(1'b0, 8'h00, 16'h1234, 1'b0);
    issue(1'b1, 8'hFF, 16'h0000, 1'b0);
    issue(1'b1, 8'h00, 16'h0000, 1'b0);
    idle(3);

    // Fill the rest back-to-back so every address has known contents.
    for (int a = 2; a < 255; a++) issue(1'b0, AW'(a), DW'($urandom), 1'b1);
    idle(2);

    // Held req_i, alternating reads: one transaction every three clocks.
    for (int i = 0; i < 10; i++) issue(1'b1, (i % 2) ? 8'hFF : 8'h02, 16'h0000, 1'b1);
    idle(2);

    // Random mix.
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(3);

    // Reset during ACCESS of a write: the write must not commit.
    issue(1'b0, 8'h02, 16'h1357, 1'b0);
    issue(1'b1, 8'h02, 16'h0000, 1'b0);
    idle(2);
    we_n = 1'b0; addr = 8'h02; din = 16'hBEEF; req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ready) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL rst_accept_timeout: ready_o stayed 0, required 1");
    end
    @(posedge clk); #1;
    req = 1'b0; junk();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_data", {16'd0, dout}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    issue(1'b1, 8'h02, 16'h0000, 1'b0);
    idle(6);

    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
